// File: rtl/cb_safe_seq_pkg.sv
// cb_safe_seq_pkg: shared state encoding and defaults for the safe-boot sequencer
package cb_safe_seq_pkg;
    localparam int NCORES_DEFAULT = 3;
    localparam int HALT_TIMEOUT_DEFAULT = 1024;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_BOOT,
        ST_RUN,
        ST_DONE
    } state_e;
    function automatic logic [1:0] cfg_nz(input logic [1:0] cfg);
        return {1'b0, |cfg};
    endfunction
endpackage

// File: rtl/cb_safe_seq_if.sv
// cb_safe_seq_if: per-core halt/resume/boot-address handshake bundle
interface cb_safe_seq_if #(
    parameter int NCORES = cb_safe_seq_pkg::NCORES_DEFAULT
);
    logic [NCORES-1:0] core_debug_req_o;
    logic [NCORES-1:0] core_halted_i;
    logic [NCORES-1:0] core_resume_o;
    logic [31:0]       core_boot_addr_o;
    modport master (
        output core_debug_req_o,
        output core_resume_o,
        output core_boot_addr_o,
        input  core_halted_i
    );
    modport slave (
        input  core_debug_req_o,
        input  core_resume_o,
        input  core_boot_addr_o,
        output core_halted_i
    );
endinterface

// File: rtl/cb_safe_seq_timer.sv
// cb_safe_seq_timer: halt-acknowledge timeout counter with clear, enable and expire
module cb_safe_seq_timer #(
    parameter int HALT_TIMEOUT = cb_safe_seq_pkg::HALT_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign expire_o = (cnt_q == W'(HALT_TIMEOUT - 1));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cb_safe_seq.sv
// cb_safe_seq: halts selected cores, boots them at a captured address and tracks the routine to completion
module cb_safe_seq
    import cb_safe_seq_pkg::*;
#(
    parameter int NCORES       = NCORES_DEFAULT,
    parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic [NCORES-1:0] master_core_i,
    input  logic [31:0]       boot_addr_i,
    output logic              end_sw_o,
    cb_safe_seq_if.master     core_if,
    input  logic              sw_done_i,
    output logic              lockstep_en_o,
    output logic              busy_o,
    output logic              error_o
);
    state_e            state_q, state_d;
    logic              start_q, arm_q, start_edge, halted_all, expire;
    logic [NCORES-1:0] mask_q, mask_d, dbg_q, res_q;
    logic              safe_q, safe_d, error_q, error_d;
    logic [1:0]        cfg_q, cfg_d;
    logic [31:0]       addr_q, addr_d, baddr_q;
    logic              lock_q, end_q, busy_q;

    // arm_q blocks a start level held high across reset release from looking like an edge
    assign start_edge = start_i & ~start_q & arm_q;
    assign halted_all = (core_if.core_halted_i & mask_q) == mask_q;

    cb_safe_seq_timer #(.HALT_TIMEOUT(HALT_TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q != ST_HALT),
        .en_i     (state_q == ST_HALT),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        safe_d  = safe_q;
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: if (start_edge) begin
                state_d = ST_HALT;
                mask_d  = safe_mode_i ? {NCORES{1'b1}} : master_core_i;
                safe_d  = safe_mode_i;
                cfg_d   = safe_configuration_i;
                addr_d  = boot_addr_i;
                error_d = 1'b0;
            end
            ST_HALT: begin
                if (!start_i) state_d = ST_IDLE;
                else if (halted_all) state_d = ST_BOOT;
                else if (expire) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end
            end
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = !start_i ? ST_IDLE : sw_done_i ? ST_DONE : ST_RUN;
            ST_DONE: state_d = !start_i ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            arm_q   <= 1'b0;
            mask_q  <= '0;
            safe_q  <= 1'b0;
            cfg_q   <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
            dbg_q   <= '0;
            res_q   <= '0;
            baddr_q <= '0;
            lock_q  <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            arm_q   <= arm_q | ~start_i;
            mask_q  <= mask_d;
            safe_q  <= safe_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            error_q <= error_d;
            dbg_q   <= (state_d == ST_HALT) ? mask_d : '0;
            res_q   <= (state_d == ST_BOOT) ? mask_d : '0;
            baddr_q <= (state_d == ST_BOOT) ? addr_d : baddr_q;
            lock_q  <= (state_d == ST_RUN) && safe_d && cfg_nz(cfg_d)[0];
            end_q   <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign core_if.core_debug_req_o = dbg_q;
    assign core_if.core_resume_o    = res_q;
    assign core_if.core_boot_addr_o = baddr_q;
    assign lockstep_en_o            = lock_q;
    assign end_sw_o                 = end_q;
    assign busy_o                   = busy_q;
    assign error_o                  = error_q;
endmodule

// File: tb/tb_cb_safe_seq.sv
// tb_cb_safe_seq: directed vectors against hand-computed expectations for cb_safe_seq
module tb_cb_safe_seq;
    localparam int NC = 3;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst_n, start, safe, sw_done;
    logic [1:0]  cfg;
    logic [2:0]  master;
    logic [31:0] addr;
    logic end_sw, lock, busy, err;
    logic seen_res;
    int checks = 0;
    int errors = 0;

    cb_safe_seq_if #(.NCORES(NC)) cif ();

    cb_safe_seq #(.NCORES(NC), .HALT_TIMEOUT(TO)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .start_i              (start),
        .safe_mode_i          (safe),
        .safe_configuration_i (cfg),
        .master_core_i        (master),
        .boot_addr_i          (addr),
        .end_sw_o             (end_sw),
        .core_if              (cif),
        .sw_done_i            (sw_done),
        .lockstep_en_o        (lock),
        .busy_o               (busy),
        .error_o              (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cif.core_resume_o != '0) seen_res = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b, input logic [2:0] d, input logic [2:0] r,
                           input logic l, input logic e, input logic er);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".dbg"}, 32'(cif.core_debug_req_o), 32'(d));
        chk({tag, ".res"}, 32'(cif.core_resume_o), 32'(r));
        chk({tag, ".lock"}, 32'(lock), 32'(l));
        chk({tag, ".end"}, 32'(end_sw), 32'(e));
        chk({tag, ".err"}, 32'(err), 32'(er));
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; safe = 1'b0; sw_done = 1'b0;
        cfg = '0; master = '0; addr = '0; cif.core_halted_i = '0; seen_res = 1'b0;
        tick(2);
        chk_out("reset", 0, 3'b000, 3'b000, 0, 0, 0);
        chk("reset.baddr", cif.core_boot_addr_o, 32'h0);
        rst_n = 1'b1;
        tick();
        // full safe-mode sequence
        safe = 1'b1; addr = 32'h0000_1000; start = 1'b1;
        tick();
        chk_out("s1.halt", 1, 3'b111, 3'b000, 0, 0, 0);
        tick(2);
        cif.core_halted_i = 3'b111;
        tick();
        chk_out("s1.boot", 1, 3'b000, 3'b111, 0, 0, 0);
        chk("s1.baddr", cif.core_boot_addr_o, 32'h0000_1000);
        cif.core_halted_i = '0;
        tick();
        chk_out("s1.run", 1, 3'b000, 3'b000, 0, 0, 0);
        sw_done = 1'b1;
        tick();
        sw_done = 1'b0;
        chk_out("s1.done", 1, 3'b000, 3'b000, 0, 1, 0);
        tick();
        chk_out("s1.hold", 1, 3'b000, 3'b000, 0, 1, 0);
        start = 1'b0;
        tick();
        chk_out("s1.idle", 0, 3'b000, 3'b000, 0, 0, 0);
        chk("s1.baddr_hold", cif.core_boot_addr_o, 32'h0000_1000);
        // master-only, wrong-core acks and early sw_done ignored
        safe = 1'b0; master = 3'b010; cfg = 2'b11; addr = 32'h2222_0000; start = 1'b1;
        tick();
        chk_out("s2.halt", 1, 3'b010, 3'b000, 0, 0, 0);
        cif.core_halted_i = 3'b101; sw_done = 1'b1;
        tick();
        sw_done = 1'b0;
        chk_out("s2.wait", 1, 3'b010, 3'b000, 0, 0, 0);
        cif.core_halted_i = 3'b010;
        tick();
        chk_out("s2.boot", 1, 3'b000, 3'b010, 0, 0, 0);
        chk("s2.baddr", cif.core_boot_addr_o, 32'h2222_0000);
        tick();
        chk_out("s2.run", 1, 3'b000, 3'b000, 0, 0, 0);
        start = 1'b0; cif.core_halted_i = '0;
        tick();
        chk_out("s2.idle", 0, 3'b000, 3'b000, 0, 0, 0);
        // halt timeout: core 2 never acknowledges
        safe = 1'b1; cfg = 2'b01; addr = 32'h0000_3333; cif.core_halted_i = 3'b011;
        seen_res = 1'b0; start = 1'b1;
        tick();
        chk_out("s3.halt", 1, 3'b111, 3'b000, 0, 0, 0);
        tick(TO - 1);
        chk_out("s3.last", 1, 3'b111, 3'b000, 0, 0, 0);
        tick();
        chk_out("s3.timeout", 1, 3'b000, 3'b000, 0, 1, 1);
        chk("s3.no_resume", 32'(seen_res), 32'd0);
        chk("s3.baddr_hold", cif.core_boot_addr_o, 32'h2222_0000);
        start = 1'b0;
        tick();
        chk_out("s3.idle", 0, 3'b000, 3'b000, 0, 0, 1);
        // lockstep run aborted by start drop; later sw_done ignored
        cfg = 2'b10; addr = 32'h0000_4000; cif.core_halted_i = 3'b111; start = 1'b1;
        tick();
        chk_out("s4.halt", 1, 3'b111, 3'b000, 0, 0, 0);
        tick();
        chk_out("s4.boot", 1, 3'b000, 3'b111, 0, 0, 0);
        tick();
        chk_out("s4.run", 1, 3'b000, 3'b000, 1, 0, 0);
        start = 1'b0;
        tick();
        chk_out("s4.abort", 0, 3'b000, 3'b000, 0, 0, 0);
        cif.core_halted_i = '0; sw_done = 1'b1;
        tick();
        sw_done = 1'b0;
        tick();
        chk_out("s4.ignored", 0, 3'b000, 3'b000, 0, 0, 0);
        // acknowledge on the timeout cycle wins
        cfg = 2'b00; start = 1'b1;
        tick();
        tick(TO - 1);
        chk_out("s5.last", 1, 3'b111, 3'b000, 0, 0, 0);
        cif.core_halted_i = 3'b111;
        tick();
        chk_out("s5.boot", 1, 3'b000, 3'b111, 0, 0, 0);
        tick();
        start = 1'b0; cif.core_halted_i = '0;
        tick();
        chk_out("s5.idle", 0, 3'b000, 3'b000, 0, 0, 0);
        // reset in RUN with start held high
        cfg = 2'b11; cif.core_halted_i = 3'b111; start = 1'b1;
        tick(3);
        chk_out("s6.run", 1, 3'b000, 3'b000, 1, 0, 0);
        cif.core_halted_i = '0;
        rst_n = 1'b0;
        #2;
        chk_out("s6.reset", 0, 3'b000, 3'b000, 0, 0, 0);
        chk("s6.baddr", cif.core_boot_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(3);
        chk_out("s6.no_edge", 0, 3'b000, 3'b000, 0, 0, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk_out("s6.restart", 1, 3'b111, 3'b000, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
